// File: rtl/i2c_regfile_pkg.sv
// Shared types and constants for the I2C slave register file.
package i2c_regfile_pkg;

  localparam int BYTE_W = 8;
  localparam int ADDR_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    PTR,
    WDATA,
    RDATA
  } state_t;

  function automatic int ptr_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/i2c_slave_serializer_rw.sv
// Bit-level I2C framing: start/stop detection, byte receive with ACK drive,
// byte transmit with master ACK sampling. SDA only changes while SCL is low.
module i2c_slave_serializer_rw
  import i2c_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scl,
  input  logic              sda_in,
  output logic              sda_out,
  output logic              start,
  output logic              stop,
  output logic              wr,
  output logic [BYTE_W-1:0] write_data,
  input  logic              wr_ack,
  input  logic              tx_en,
  output logic              rd_req,
  input  logic [BYTE_W-1:0] read_data,
  output logic              master_ack,
  output logic              rd_done
);

  logic              r_scl_d;
  logic              r_sda_d;
  logic [3:0]        r_bit_cnt;
  logic              r_ninth;
  logic              r_tx;
  logic              r_ack;
  logic [BYTE_W-1:0] r_shift;
  logic              r_sda_out;

  logic w_scl_rise;
  logic w_scl_fall;

  assign w_scl_rise = scl & ~r_scl_d;
  assign w_scl_fall = ~scl & r_scl_d;

  assign start      = scl & r_scl_d & r_sda_d & ~sda_in;
  assign stop       = scl & r_scl_d & ~r_sda_d & sda_in;
  assign wr         = w_scl_rise & ~r_tx & (r_bit_cnt == 4'd7);
  assign write_data = {r_shift[BYTE_W-2:0], sda_in};
  assign rd_done    = w_scl_rise & r_tx & (r_bit_cnt == 4'd8);
  assign master_ack = ~sda_in;
  assign rd_req     = w_scl_fall & r_ninth & tx_en;
  assign sda_out    = r_sda_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_d   <= 1'b1;
      r_sda_d   <= 1'b1;
      r_bit_cnt <= 4'd0;
      r_ninth   <= 1'b0;
      r_tx      <= 1'b0;
      r_ack     <= 1'b0;
      r_shift   <= '0;
      r_sda_out <= 1'b1;
    end else begin
      r_scl_d <= scl;
      r_sda_d <= sda_in;
      if (start || stop) begin
        r_bit_cnt <= 4'd0;
        r_ninth   <= 1'b0;
        r_tx      <= 1'b0;
        r_ack     <= 1'b0;
        r_sda_out <= 1'b1;
      end else if (w_scl_rise) begin
        if (r_bit_cnt < 4'd8) begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (!r_tx) r_shift <= write_data;
          if (wr) r_ack <= wr_ack;
        end else begin
          r_ninth <= 1'b1;
        end
      end else if (w_scl_fall) begin
        if ((r_bit_cnt == 4'd8) && !r_ninth) begin
          // ninth clock: slave ACK on receive, bus released for master on transmit
          r_sda_out <= r_tx ? 1'b1 : ~r_ack;
        end else if (r_ninth) begin
          r_bit_cnt <= 4'd0;
          r_ninth   <= 1'b0;
          r_ack     <= 1'b0;
          if (tx_en) begin
            r_tx      <= 1'b1;
            r_sda_out <= read_data[BYTE_W-1];
            r_shift   <= {read_data[BYTE_W-2:0], 1'b0};
          end else begin
            r_tx      <= 1'b0;
            r_sda_out <= 1'b1;
          end
        end else if (r_tx && (r_bit_cnt != 4'd0)) begin
          r_sda_out <= r_shift[BYTE_W-1];
          r_shift   <= {r_shift[BYTE_W-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave register file with shadowed writes committed on stop.
// Read-back path compiled in only when I2C_REGFILE_READ_EN is defined.
//   state | meaning
//   IDLE  | ignore bus until next start
//   ADDR  | receive address byte
//   PTR   | receive register pointer
//   WDATA | receive data bytes into shadow
//   RDATA | transmit committed register bytes
module i2c_slave_regfile
  import i2c_regfile_pkg::*;
#(
  parameter logic [ADDR_W-1:0] I2C_ADDRESS = 7'h00,
  parameter int                NUM_REGS    = 4,
  parameter int                REG_BYTES   = 2,
  parameter logic [NUM_REGS*REG_BYTES*BYTE_W-1:0] RESET_VALUE = '0
)
(
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               scl,
  input  logic                               sda_in,
  output logic                               sda_out,
  output logic [NUM_REGS*REG_BYTES*BYTE_W-1:0] reg_out,
  output logic                               update
);

  localparam int REG_W = REG_BYTES * BYTE_W;
  localparam int TOT_W = NUM_REGS * REG_W;
  localparam int PW    = ptr_w(NUM_REGS);
  localparam int IDX_W = (REG_BYTES > 1) ? $clog2(REG_BYTES) : 1;

  localparam logic [PW-1:0]     PTR_LAST   = PW'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(REG_BYTES - 1);
  localparam logic [BYTE_W-1:0] NUM_REGS_B = BYTE_W'(NUM_REGS);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PW-1:0]      r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [REG_W-1:0]   r_stage;
  logic [TOT_W-1:0]   r_shadow;
  logic               r_pend;
  logic [TOT_W-1:0]   r_reg_out;
  logic               r_update;

  logic               w_start;
  logic               w_stop;
  logic               w_wr;
  logic [BYTE_W-1:0]  w_write_data;
  logic               w_wr_ack;
  logic               w_tx_en;
  logic               w_rd_req;
  logic [BYTE_W-1:0]  w_read_data;
  logic               w_master_ack;
  logic               w_rd_done;

  logic [PW-1:0]      w_ptr_inc;
  logic               w_addr_hit;
  logic [REG_W-1:0]   w_stage_nxt;

  assign w_ptr_inc   = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
  assign w_addr_hit  = (w_write_data[BYTE_W-1:1] == I2C_ADDRESS);
  assign w_stage_nxt = REG_W'({r_stage, w_write_data});

  assign reg_out = r_reg_out;
  assign update  = r_update;

  i2c_slave_serializer_rw u_ser (
    .clk        (clk),
    .reset_n    (reset_n),
    .scl        (scl),
    .sda_in     (sda_in),
    .sda_out    (sda_out),
    .start      (w_start),
    .stop       (w_stop),
    .wr         (w_wr),
    .write_data (w_write_data),
    .wr_ack     (w_wr_ack),
    .tx_en      (w_tx_en),
    .rd_req     (w_rd_req),
    .read_data  (w_read_data),
    .master_ack (w_master_ack),
    .rd_done    (w_rd_done)
  );

`ifdef I2C_REGFILE_READ_EN
  int w_rd_base;

  assign w_tx_en = (r_state == RDATA);

  always_comb begin
    w_rd_base   = int'(r_ptr) * REG_W + (REG_BYTES - 1 - int'(r_idx)) * BYTE_W;
    w_read_data = r_reg_out[w_rd_base +: BYTE_W];
  end
`else
  logic w_unused_rd;

  assign w_tx_en     = 1'b0;
  assign w_read_data = '0;
  assign w_unused_rd = w_rd_req ^ w_rd_done ^ w_master_ack;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_ack    = 1'b0;
    if (w_stop) begin
      w_state_nxt = IDLE;
    end else if (w_start) begin
      w_state_nxt = ADDR;
    end else if (w_wr) begin
      case (r_state)
        ADDR: begin
          if (!w_addr_hit) begin
            w_state_nxt = IDLE;
          end else if (!w_write_data[0]) begin
            w_wr_ack    = 1'b1;
            w_state_nxt = PTR;
          end else begin
`ifdef I2C_REGFILE_READ_EN
            w_wr_ack    = 1'b1;
            w_state_nxt = RDATA;
`else
            w_state_nxt = IDLE;
`endif
          end
        end
        PTR: begin
          if (w_write_data < NUM_REGS_B) begin
            w_wr_ack    = 1'b1;
            w_state_nxt = WDATA;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        WDATA:   w_wr_ack = 1'b1;
        default: ;
      endcase
    end else if (w_rd_done && (r_state == RDATA) && !w_master_ack) begin
      w_state_nxt = IDLE;
    end
  end

  // Bytes are staged so that a register only reaches its shadow once complete.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr     <= '0;
      r_idx     <= '0;
      r_stage   <= '0;
      r_shadow  <= RESET_VALUE;
      r_pend    <= 1'b0;
      r_reg_out <= RESET_VALUE;
      r_update  <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (w_stop) begin
        r_idx <= '0;
        if (r_pend) begin
          r_reg_out <= r_shadow;
          r_update  <= 1'b1;
          r_pend    <= 1'b0;
        end
      end else if (w_start) begin
        r_idx <= '0;
      end else if (w_wr && w_wr_ack) begin
        if (r_state == PTR) begin
          r_ptr <= w_write_data[PW-1:0];
          r_idx <= '0;
        end else if (r_state == WDATA) begin
          r_stage <= w_stage_nxt;
          if (r_idx == IDX_LAST) begin
            r_shadow[int'(r_ptr)*REG_W +: REG_W] <= w_stage_nxt;
            r_pend <= 1'b1;
            r_idx  <= '0;
            r_ptr  <= w_ptr_inc;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
      end else if (w_rd_req) begin
        if (r_idx == IDX_LAST) begin
          r_idx <= '0;
          r_ptr <= w_ptr_inc;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: writes, wrap, discard, NACKs, reads, reset.
module tb_i2c_slave_regfile;

  localparam logic [63:0] RV = 64'h4444_3333_2222_1111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_bus;
  logic        sda_out;
  logic        update;
  logic [63:0] reg_out;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  assign sda_bus = m_sda & sda_out;

  i2c_slave_regfile #(
    .I2C_ADDRESS (7'h21),
    .NUM_REGS    (4),
    .REG_BYTES   (2),
    .RESET_VALUE (RV)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .scl     (scl),
    .sda_in  (sda_bus),
    .sda_out (sda_out),
    .reg_out (reg_out),
    .update  (update)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (update) upd_cnt <= upd_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wq;
    repeat (4) @(negedge clk);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; wq;
    scl = 1'b1;   wq;
    m_sda = 1'b0; wq;
    scl = 1'b0;   wq;
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; wq;
    scl = 1'b1;   wq;
    m_sda = 1'b1; wq;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; wq;
      scl = 1'b1;   wq;
      scl = 1'b0;
    end
    m_sda = 1'b1; wq;
    scl = 1'b1;   wq;
    acked = (sda_bus == 1'b0);
    scl = 1'b0;   wq;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wq;
      scl = 1'b1; wq;
      b[i] = sda_bus;
      scl = 1'b0;
    end
    m_sda = nack; wq;
    scl = 1'b1;   wq;
    scl = 1'b0;
    m_sda = 1'b1; wq;
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         u0;
    logic       low_seen;

    repeat (3) @(negedge clk);
    check("reset_reg_out", reg_out, RV);
    check("reset_sda_out", {63'd0, sda_out}, 64'd1);
    check("reset_update", {63'd0, update}, 64'd0);
    reset_n = 1'b1;
    wq;

    // single register write
    u0 = upd_cnt;
    i2c_start;
    write_byte(8'h42, ack); check("w1_addr_ack", {63'd0, ack}, 64'd1);
    check("w1_ack_released", {63'd0, sda_out}, 64'd1);
    write_byte(8'h01, ack); check("w1_ptr_ack", {63'd0, ack}, 64'd1);
    write_byte(8'hBE, ack); check("w1_d0_ack", {63'd0, ack}, 64'd1);
    write_byte(8'hEF, ack); check("w1_d1_ack", {63'd0, ack}, 64'd1);
    check("w1_no_update_before_stop", 64'(upd_cnt - u0), 64'd0);
    i2c_stop; wq;
    check("w1_update_once", 64'(upd_cnt - u0), 64'd1);
    check("w1_reg_out", reg_out, 64'h4444_3333_BEEF_1111);

    // pointer wrap across reg3 -> reg0
    u0 = upd_cnt;
    i2c_start;
    write_byte(8'h42, ack);
    write_byte(8'h03, ack); check("w2_ptr_ack", {63'd0, ack}, 64'd1);
    write_byte(8'h11, ack);
    write_byte(8'h22, ack);
    write_byte(8'h33, ack);
    write_byte(8'h44, ack); check("w2_last_ack", {63'd0, ack}, 64'd1);
    i2c_stop; wq;
    check("w2_update_once", 64'(upd_cnt - u0), 64'd1);
    check("w2_reg_out", reg_out, 64'h1122_3333_BEEF_3344);

    // partial register discarded, then out-of-range pointer
    u0 = upd_cnt;
    i2c_start;
    write_byte(8'h42, ack);
    write_byte(8'h02, ack);
    write_byte(8'hAA, ack);
    i2c_stop; wq;
    check("w3_no_update", 64'(upd_cnt - u0), 64'd0);
    check("w3_reg_out", reg_out, 64'h1122_3333_BEEF_3344);
    i2c_start;
    write_byte(8'h42, ack); check("w4_addr_ack", {63'd0, ack}, 64'd1);
    write_byte(8'h07, ack); check("w4_bad_ptr_nack", {63'd0, ack}, 64'd0);
    i2c_stop; wq;

`ifdef I2C_REGFILE_READ_EN
    // pointer still 2 after the rejected pointer byte
    i2c_start;
    write_byte(8'h43, ack); check("r0_addr_ack", {63'd0, ack}, 64'd1);
    read_byte(1'b0, rd);    check("r0_byte0", {56'd0, rd}, 64'h33);
    read_byte(1'b1, rd);    check("r0_byte1", {56'd0, rd}, 64'h33);
    i2c_stop; wq;

    // write pointer, repeated start, read back
    u0 = upd_cnt;
    i2c_start;
    write_byte(8'h42, ack);
    write_byte(8'h01, ack);
    i2c_start;
    write_byte(8'h43, ack); check("r1_addr_ack", {63'd0, ack}, 64'd1);
    read_byte(1'b0, rd);    check("r1_byte0", {56'd0, rd}, 64'hBE);
    read_byte(1'b1, rd);    check("r1_byte1", {56'd0, rd}, 64'hEF);
    check("r1_sda_released", {63'd0, sda_out}, 64'd1);
    wq;
    check("r1_sda_still_released", {63'd0, sda_out}, 64'd1);
    i2c_stop; wq;
    check("r1_no_update", 64'(upd_cnt - u0), 64'd0);
`else
    // read address refused, bus left released
    i2c_start;
    write_byte(8'h43, ack); check("rd_dis_nack", {63'd0, ack}, 64'd0);
    low_seen = 1'b0;
    m_sda = 1'b1;
    for (int i = 0; i < 9; i++) begin
      wq;
      if (sda_out !== 1'b1) low_seen = 1'b1;
      scl = 1'b1; wq;
      if (sda_out !== 1'b1) low_seen = 1'b1;
      scl = 1'b0;
    end
    wq;
    check("rd_dis_sda_high", {63'd0, low_seen}, 64'd0);
    i2c_stop; wq;
    check("rd_dis_sda_after_stop", {63'd0, sda_out}, 64'd1);
`endif

    // wrong address: everything NACKed until stop
    u0 = upd_cnt;
    i2c_start;
    write_byte(8'h44, ack); check("wa_addr_nack", {63'd0, ack}, 64'd0);
    write_byte(8'h01, ack); check("wa_byte_nack", {63'd0, ack}, 64'd0);
    write_byte(8'h55, ack); check("wa_byte2_nack", {63'd0, ack}, 64'd0);
    i2c_stop; wq;
    check("wa_no_update", 64'(upd_cnt - u0), 64'd0);
    check("wa_reg_out", reg_out, 64'h1122_3333_BEEF_3344);

    // reset in the middle of a data byte
    i2c_start;
    write_byte(8'h42, ack);
    write_byte(8'h00, ack);
    write_byte(8'h12, ack); check("rst_pre_ack", {63'd0, ack}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      m_sda = 1'b0; wq;
      scl = 1'b1;   wq;
      scl = 1'b0;
    end
    reset_n = 1'b0; wq;
    check("rst_reg_out", reg_out, RV);
    check("rst_sda_out", {63'd0, sda_out}, 64'd1);
    check("rst_update", {63'd0, update}, 64'd0);
    reset_n = 1'b1; wq;
    u0 = upd_cnt;
    write_byte(8'h42, ack); check("rst_no_start_nack", {63'd0, ack}, 64'd0);
    i2c_stop; wq;
    check("rst_no_update", 64'(upd_cnt - u0), 64'd0);
    check("rst_reg_out_after", reg_out, RV);

    // fresh transaction after reset
    u0 = upd_cnt;
    i2c_start;
    write_byte(8'h42, ack); check("post_addr_ack", {63'd0, ack}, 64'd1);
    write_byte(8'h00, ack);
    write_byte(8'hCA, ack);
    write_byte(8'hFE, ack);
    i2c_stop; wq;
    check("post_update_once", 64'(upd_cnt - u0), 64'd1);
    check("post_reg_out", reg_out, 64'h4444_3333_2222_CAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile.md
I2C_SLAVE_REGFILE -- requirements
Module: i2c_slave_regfile

Interface
REQ-001 SHALL have parameter I2C_ADDRESS, default 7'h00: 7-bit slave address matched against address-byte bits [7:1].
REQ-002 SHALL have parameter NUM_REGS, default 4: register count, legal range 2..16.
REQ-003 SHALL have parameter REG_BYTES, default 2: bytes per register, legal range 1..4.
REQ-004 SHALL have parameter RESET_VALUE, default 0: NUM_REGS*REG_BYTES*8-bit reset image of reg_out.
REQ-005 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port scl, input, 1: SCL, already synchronised to clk.
REQ-008 SHALL have port sda_in, input, 1: SDA, already synchronised to clk.
REQ-009 SHALL have port sda_out, output, 1: open-drain SDA drive; 0 pulls low, 1 releases.
REQ-010 SHALL have port reg_out, output, NUM_REGS*REG_BYTES*8: committed registers; register k at bits [(k+1)*REG_BYTES*8-1 : k*REG_BYTES*8].
REQ-011 SHALL have port update, output, 1: one-cycle pulse when reg_out is committed.

Function
REQ-012 SHALL implement states IDLE, ADDR, PTR, WDATA and RDATA; a start condition in any state goes to ADDR, clears the byte index and keeps the pointer.
REQ-013 SHALL ACK the address byte if bits [7:1] equal I2C_ADDRESS; on mismatch SHALL NACK and go to IDLE until the next start.
REQ-014 SHALL go to PTR after a matched write address (bit0 = 0); in PTR it SHALL load the next byte as the register pointer.
REQ-015 SHALL ACK a pointer byte below NUM_REGS and go to WDATA; a pointer byte >= NUM_REGS SHALL be NACKed, leave the pointer unchanged and go to IDLE.
REQ-016 In WDATA, each ACKed byte SHALL fill shadow[ptr], MSB byte first.
REQ-017 After REG_BYTES bytes in WDATA, the shadow SHALL be marked pending, the byte index SHALL reset and ptr SHALL increment, wrapping from NUM_REGS-1 to 0.
REQ-018 On stop, if any register is pending, all shadows SHALL copy to reg_out and update SHALL pulse high for exactly one cycle, one cycle after stop is detected; reg_out changes in that same cycle.
REQ-019 Partially written registers SHALL be discarded at stop or start; a repeated start SHALL keep pending registers for the next stop.
REQ-020 SHALL drive the ACK low before the ninth SCL rising edge and release it after the following SCL fall.
REQ-021 A matched read address (bit0 = 1) SHALL go to RDATA, which transmits committed reg_out[ptr] bytes MSB first.
REQ-022 In RDATA, data bits SHALL change only while SCL is low.
REQ-023 After REG_BYTES transmitted bytes, ptr SHALL increment with wrap.
REQ-024 A master ACK SHALL continue the read; a master NACK SHALL release SDA and go to IDLE.
REQ-025 A stop in any state SHALL go to IDLE with sda_out = 1.

Reset
REQ-026 reset_n low SHALL force, asynchronously, reg_out = RESET_VALUE, shadows = RESET_VALUE, update = 0, sda_out = 1, ptr = 0, no pending registers, state IDLE.
REQ-027 Reset mid-transaction SHALL abandon the transaction without committing; after reset the block SHALL wait for a fresh start.

Configuration
REQ-028 Macro I2C_REGFILE_READ_EN defined SHALL compile in RDATA and transmit logic.
REQ-029 Without I2C_REGFILE_READ_EN, a matched read address SHALL be NACKed, go to IDLE and leave sda_out = 1 for the rest of the transaction.

Structure
REQ-030 Shared package i2c_regfile_pkg SHALL hold the state enum, BYTE_W = 8, ADDR_W = 7, and a pointer-width function $clog2(NUM_REGS).
REQ-031 Bit-level framing SHALL live in one sub-module, i2c_slave_serializer_rw, with these signals:
- start, stop: one-cycle strobes
- wr, write_data: one-cycle strobe with received byte
- wr_ack: ACK decision from the parent
- rd_req, read_data: byte request and byte to transmit
- master_ack: master's ACK/NACK after a transmitted byte

Verification (I2C_ADDRESS = 7'h21, NUM_REGS = 4, REG_BYTES = 2, READ_EN defined)
REQ-032 S,42,01,BE,EF,P -> all bytes ACKed; update pulses once; reg_out[31:16] = 16'hBEEF; other registers unchanged.
REQ-033 S,42,03,11,22,33,44,P -> reg3 = 16'h1122; reg0 = 16'h3344 (pointer wrap); one update pulse.
REQ-034 S,42,02,AA,P -> no update; reg2 unchanged (partial discard). Then S,42,07 -> 07 NACKed; pointer unchanged.
REQ-035 S,42,01,Sr,43,rd,rd(NACK),P -> slave returns BE,EF; SDA released after master NACK.
REQ-036 S,44 (wrong address) -> NACK; later bytes ignored; reset_n pulsed mid-WDATA -> reg_out = RESET_VALUE, sda_out = 1.
REQ-037 Build without I2C_REGFILE_READ_EN: S,43 -> NACK; sda_out stays 1 until stop.
